// File: rtl/clock_switch_ctrl_if.sv
// clock_switch_ctrl_if: request handshake between the register file and the clock switch sequencer
interface clock_switch_ctrl_if;
    logic req_valid;
    logic req_ready;
    logic req_src_ext;
    logic req_out_en;
    modport master (output req_valid, req_src_ext, req_out_en, input req_ready);
    modport slave (input req_valid, req_src_ext, req_out_en, output req_ready);
endinterface

// File: rtl/clock_switch_ctrl.sv
// clock_switch_ctrl: sequences crypto-clock source select (j16_sel) and CW clock-output enable (k16_sel)
// so the mux/ODDR stage never sees an unsafe change. Define CLKSEL_HEARTBEAT_EN to add the
// post-switch heartbeat verification state and the hb_toggle port.
module clock_switch_ctrl #(
    parameter int SETTLE_CYCLES = 16,
    parameter int BUSY_TIMEOUT  = 1024,
    parameter int HB_TOGGLES    = 4,
    parameter int HB_TIMEOUT    = 4096
) (
    input  logic                      usb_clk,
    input  logic                      resetn,
    clock_switch_ctrl_if.slave        req,
    input  logic                      core_busy,
    input  logic                      err_clr,
`ifdef CLKSEL_HEARTBEAT_EN
    input  logic                      hb_toggle,
`endif
    output logic                      j16_sel,
    output logic                      k16_sel,
    output logic                      switching,
    output logic [1:0]                status_err
);
    localparam int MAX_AB = (SETTLE_CYCLES > BUSY_TIMEOUT) ? SETTLE_CYCLES : BUSY_TIMEOUT;
    localparam int MAX_CD = (HB_TOGGLES > HB_TIMEOUT) ? HB_TOGGLES : HB_TIMEOUT;
    localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAXP) + 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CORE,
        GATE_OFF,
        SWITCH,
`ifdef CLKSEL_HEARTBEAT_EN
        VERIFY,
`endif
        GATE_ON
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          j16_q, j16_d, k16_q, k16_d;
    logic          tgt_src_q, tgt_src_d, tgt_oe_q, tgt_oe_d;
    logic          req_ready_q, req_ready_d;
    logic [1:0]    err_q, err_d, err_set;
    logic          accept;
`ifdef CLKSEL_HEARTBEAT_EN
    logic [2:0]    hb_sync_q, hb_sync_d;
    logic [CW-1:0] hb_cnt_q, hb_cnt_d;
    logic          orig_src_q, orig_src_d;
    logic          hb_edge;
`endif

    assign req.req_ready = req_ready_q;
    assign j16_sel       = j16_q;
    assign k16_sel       = k16_q;
    assign switching     = (state_q != IDLE);
    assign status_err    = err_q;
    assign accept        = (state_q == IDLE) && req_ready_q && req.req_valid;

    // next-state, counter reload on each state entry, and output sequencing
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
        j16_d     = j16_q;
        k16_d     = k16_q;
        tgt_src_d = tgt_src_q;
        tgt_oe_d  = tgt_oe_q;
        err_set   = 2'b00;
`ifdef CLKSEL_HEARTBEAT_EN
        hb_sync_d  = {hb_sync_q[1:0], hb_toggle};
        hb_edge    = hb_sync_q[2] ^ hb_sync_q[1];
        hb_cnt_d   = hb_cnt_q;
        orig_src_d = orig_src_q;
`endif
        case (state_q)
            IDLE: if (accept) begin
                state_d   = WAIT_CORE;
                cnt_d     = CW'(BUSY_TIMEOUT - 1);
                tgt_src_d = req.req_src_ext;
                tgt_oe_d  = req.req_out_en;
`ifdef CLKSEL_HEARTBEAT_EN
                orig_src_d = j16_q;
`endif
            end
            WAIT_CORE: if (!core_busy) begin
                state_d = (tgt_src_q != j16_q) ? GATE_OFF : GATE_ON;
                k16_d   = (tgt_src_q != j16_q) ? 1'b0 : k16_q;
                cnt_d   = CW'(SETTLE_CYCLES - 1);
            end else if (cnt_q == '0) begin
                state_d    = IDLE;
                err_set[0] = 1'b1;
            end
            GATE_OFF: if (cnt_q == '0) begin
                state_d = SWITCH;
                j16_d   = tgt_src_q;
                cnt_d   = CW'(SETTLE_CYCLES - 1);
            end
`ifdef CLKSEL_HEARTBEAT_EN
            SWITCH: if (cnt_q == '0) begin
                state_d  = VERIFY;
                cnt_d    = CW'(HB_TIMEOUT - 1);
                hb_cnt_d = '0;
            end
            VERIFY: if (hb_edge && hb_cnt_q == CW'(HB_TOGGLES - 1)) begin
                state_d = GATE_ON;
            end else if (cnt_q == '0) begin
                state_d    = IDLE;
                err_set[1] = 1'b1;
                j16_d      = orig_src_q;
                k16_d      = 1'b0;
            end else begin
                hb_cnt_d = hb_edge ? hb_cnt_q + CW'(1) : hb_cnt_q;
            end
`else
            SWITCH: if (cnt_q == '0) state_d = GATE_ON;
`endif
            GATE_ON: begin
                state_d = IDLE;
                k16_d   = tgt_oe_q;
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_q == IDLE) && !accept;
        err_d       = (err_q & ~{2{err_clr}}) | err_set;
    end

    // state and datapath registers; reset forces PLL1, output gated, idle
    always_ff @(posedge usb_clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            j16_q       <= 1'b0;
            k16_q       <= 1'b0;
            tgt_src_q   <= 1'b0;
            tgt_oe_q    <= 1'b0;
            req_ready_q <= 1'b1;
            err_q       <= 2'b00;
`ifdef CLKSEL_HEARTBEAT_EN
            hb_sync_q  <= 3'b000;
            hb_cnt_q   <= '0;
            orig_src_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            j16_q       <= j16_d;
            k16_q       <= k16_d;
            tgt_src_q   <= tgt_src_d;
            tgt_oe_q    <= tgt_oe_d;
            req_ready_q <= req_ready_d;
            err_q       <= err_d;
`ifdef CLKSEL_HEARTBEAT_EN
            hb_sync_q  <= hb_sync_d;
            hb_cnt_q   <= hb_cnt_d;
            orig_src_q <= orig_src_d;
`endif
        end
    end
endmodule

// File: tb/tb_clock_switch_ctrl.sv
// tb_clock_switch_ctrl: scoreboard bench for clock_switch_ctrl (default build)
module tb_clock_switch_ctrl;
    localparam int S  = 16;
    localparam int BT = 1024;

    typedef struct {
        int         lat;
        int         j_cyc;
        int         k_rise;
        logic       j;
        logic       k;
        logic [1:0] err;
    } exp_t;

    logic       usb_clk = 1'b0;
    logic       resetn;
    logic       core_busy;
    logic       err_clr;
    logic       j16_sel;
    logic       k16_sel;
    logic       switching;
    logic [1:0] status_err;
`ifdef CLKSEL_HEARTBEAT_EN
    logic       hb_toggle = 1'b0;
    always #50 hb_toggle = ~hb_toggle;
`endif

    int         n_chk  = 0;
    int         n_pass = 0;
    exp_t       sb[$];
    logic       m_j16  = 1'b0;
    logic       m_k16  = 1'b0;
    logic [1:0] m_err  = 2'b00;

    clock_switch_ctrl_if req_if ();

    clock_switch_ctrl dut (
        .usb_clk    (usb_clk),
        .resetn     (resetn),
        .req        (req_if),
        .core_busy  (core_busy),
        .err_clr    (err_clr),
`ifdef CLKSEL_HEARTBEAT_EN
        .hb_toggle  (hb_toggle),
`endif
        .j16_sel    (j16_sel),
        .k16_sel    (k16_sel),
        .switching  (switching),
        .status_err (status_err)
    );

    always #5 usb_clk = ~usb_clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // push the expectation, issue the request, then pop and compare when req_ready returns
    task automatic send(input logic src, input logic oe, input logic glitch);
        exp_t e;
        logic chg, pj, pk;
        int   lat, jc, kr, bad;
        chg = (src != m_j16);
        if (core_busy) begin
            e.lat = BT + 1; e.j_cyc = -1; e.k_rise = -1;
            e.j = m_j16; e.k = m_k16; e.err = m_err | 2'b01;
        end else begin
            e.lat    = chg ? 2 * S + 3 : 3;
            e.j_cyc  = chg ? S + 1 : -1;
            e.k_rise = (oe && (chg || !m_k16)) ? (chg ? 2 * S + 2 : 2) : -1;
            e.j = src; e.k = oe; e.err = m_err;
        end
        sb.push_back(e);
        m_j16 = e.j; m_k16 = e.k; m_err = e.err;
        pj = j16_sel; pk = k16_sel;
        lat = -1; jc = -1; kr = -1; bad = 0;
        req_if.req_valid = 1'b1; req_if.req_src_ext = src; req_if.req_out_en = oe;
        @(negedge usb_clk);
        req_if.req_valid = 1'b0;
        check("accept_ready", req_if.req_ready, 0);
        check("accept_switching", switching, 1);
        for (int k = 1; k <= 3000; k++) begin
            @(negedge usb_clk);
            if (j16_sel != pj) begin
                if (jc < 0) jc = k;
                if (k16_sel) bad++;
            end
            if (k16_sel && !pk) begin
                if (kr < 0) kr = k;
                else bad++;
            end
            pj = j16_sel; pk = k16_sel;
            req_if.req_valid   = glitch && (k == 5);
            req_if.req_src_ext = (glitch && k == 5) ? ~src : src;
            if (req_if.req_ready) begin
                lat = k;
                break;
            end
        end
        req_if.req_valid = 1'b0;
        e = sb.pop_front();
        check("latency", lat, e.lat);
        check("j16_change_cycle", jc, e.j_cyc);
        check("k16_rise_cycle", kr, e.k_rise);
        check("j16_final", j16_sel, e.j);
        check("k16_final", k16_sel, e.k);
        check("status_err", status_err, e.err);
        check("ordering", bad, 0);
    endtask

    initial begin
        resetn = 1'b0; core_busy = 1'b0; err_clr = 1'b0;
        req_if.req_valid = 1'b0; req_if.req_src_ext = 1'b0; req_if.req_out_en = 1'b0;
        repeat (3) @(negedge usb_clk);
        check("rst_j16", j16_sel, 0);
        check("rst_k16", k16_sel, 0);
        check("rst_ready", req_if.req_ready, 1);
        check("rst_switching", switching, 0);
        check("rst_err", status_err, 0);
        resetn = 1'b1;
        @(negedge usb_clk);
        send(1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b0);
        core_busy = 1'b1;
        send(1'b0, 1'b1, 1'b0);
        err_clr = 1'b1;
        @(negedge usb_clk);
        err_clr = 1'b0;
        m_err = 2'b00;
        check("err_clr", status_err, m_err);
        repeat (10) @(negedge usb_clk);
        core_busy = 1'b0;
        send(1'b0, 1'b0, 1'b0);
        req_if.req_valid = 1'b1; req_if.req_src_ext = 1'b1; req_if.req_out_en = 1'b1;
        @(negedge usb_clk);
        req_if.req_valid = 1'b0;
        repeat (20) @(negedge usb_clk);
        check("pre_rst_j16", j16_sel, 1);
        check("pre_rst_switching", switching, 1);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_j16", j16_sel, 0);
        check("mid_rst_k16", k16_sel, 0);
        check("mid_rst_ready", req_if.req_ready, 1);
        check("mid_rst_switching", switching, 0);
        @(negedge usb_clk);
        resetn = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/clock_switch_ctrl.md
Name: clock_switch_ctrl

Overview:
- Sequences changes to the crypto-clock source select (J16 path) and the CW clock-output enable (K16 path) from register writes in the usb_clk domain.
- The clock mux/ODDR stage consumes `j16_sel` and `k16_sel` directly; this block guarantees the stage never sees them change at an unsafe moment.
- It waits for the crypto core to go idle, gates the output clock off, switches the source, lets it settle, then re-enables output.
- Sticky error flags are reported to the register file.

Parameters:
- SETTLE_CYCLES, 16: usb_clk cycles held in GATE_OFF and in SWITCH (min 1).
- BUSY_TIMEOUT, 1024: max usb_clk cycles spent waiting for core_busy=0.
- HB_TOGGLES, 4: heartbeat toggles required after a source switch (optional feature only).
- HB_TIMEOUT, 4096: usb_clk cycles allowed to see HB_TOGGLES (optional feature only).

Ports:
- usb_clk  input  1  sole clock, buffered USB clock.
- resetn  input  1  asynchronous active-low reset.
- req_valid  input  1  switch request valid.
- req_ready  output  1  block idle, request accepted when req_valid&req_ready.
- req_src_ext  input  1  requested source: 1=CW clkin, 0=PLL1.
- req_out_en  input  1  requested CW clock-output enable.
- core_busy  input  1  crypto core operation in progress (synchronous to usb_clk).
- err_clr  input  1  single-cycle pulse, clears status_err.
- hb_toggle  input  1  crypto-clock-domain heartbeat toggle (optional feature only).
- j16_sel  output  1  source select to clock mux.
- k16_sel  output  1  output-clock enable to ODDR CE.
- switching  output  1  high while state != IDLE.
- status_err  output  2  sticky: [0] busy timeout, [1] heartbeat failure.

Behaviour:
- Reset (async, resetn=0), all immediate:
  - j16_sel=0 (PLL1), k16_sel=0, req_ready=1, switching=0, status_err=0, state=IDLE.
  - Assertion mid-sequence aborts it; no partial restore.
- Accept: in IDLE, req_valid=1 latches req_src_ext/req_out_en into tgt_src/tgt_oe.
  - req_ready=0 and switching=1 from the next cycle.
  - req_valid is ignored while req_ready=0.
- States: IDLE, WAIT_CORE, GATE_OFF, SWITCH, VERIFY (macro only), GATE_ON.
- IDLE -> WAIT_CORE on accept.
- WAIT_CORE:
  - core_busy=0 -> GATE_OFF if tgt_src!=j16_sel, else GATE_ON.
  - Counter reaches BUSY_TIMEOUT with core_busy still 1 -> set status_err[0], outputs unchanged, -> IDLE.
- GATE_OFF:
  - k16_sel=0 on entry; hold SETTLE_CYCLES cycles -> SWITCH.
- SWITCH:
  - j16_sel=tgt_src on entry; hold SETTLE_CYCLES cycles -> VERIFY (macro) or GATE_ON.
- GATE_ON:
  - k16_sel=tgt_oe; one cycle -> IDLE; req_ready=1 the following cycle.
- Request identical to current outputs: still passes WAIT_CORE -> GATE_ON; total 3 cycles to req_ready with core idle.
- Latency, accept to req_ready=1 with core idle and source change: 2*SETTLE_CYCLES+3 cycles (no macro).
- Ordering: j16_sel never changes while k16_sel=1; k16_sel rises at most once per request.
- Counter:
  - One shared down-counter, width $clog2(max parameter)+1, reloaded on every state entry.
  - No wrap: holds at 0.
- status_err:
  - Bits sticky until err_clr.
  - err_clr in the same cycle as a new error: error bit set wins, other bit cleared.

Optional Feature:
- Macro CLKSEL_HEARTBEAT_EN.
- Defined:
  - hb_toggle passes through a 2-FF synchronizer; edges are detected in usb_clk.
  - VERIFY counts edges; HB_TOGGLES edges within HB_TIMEOUT cycles -> GATE_ON.
  - Timeout -> set status_err[1], restore j16_sel to the pre-request value, k16_sel=0, -> IDLE.
  - VERIFY is entered only after SWITCH.
- Undefined: the hb_toggle port is absent, there is no VERIFY state, and status_err[1] is tied 0.

Test Plan:
- Defaults, core idle: request src=1,oe=1 -> k16_sel stays 0; j16_sel rises 17 cycles after accept; k16_sel rises at cycle 34; req_ready=1 at cycle 35.
- Output enable only: start src=1,oe=1; request src=1,oe=0 -> j16_sel stays 1, k16_sel falls, req_ready back 3 cycles after accept.
- core_busy held 1 for 2000 cycles -> status_err=2'b01 after 1024 cycles, j16/k16 unchanged; err_clr pulse -> status_err=0.
- resetn low mid-SWITCH with j16_sel=1 -> next sample j16_sel=0, k16_sel=0, req_ready=1, switching=0.
- Macro defined, hb_toggle static after switching to ext -> status_err[1]=1 after 4096 VERIFY cycles, j16_sel back to 0, k16_sel=0.
- Macro defined, hb_toggle toggling every 10 cycles -> VERIFY exits after 4 synchronized edges; k16_sel=tgt_oe; status_err=0.
